// File: rtl/i2s_tx.sv
// Master I2S transmitter: generates o_sck/o_ws from i_clk and shifts out
// DATA_W-bit stereo samples MSB-first, one sck after each word-select edge.
// Samples enter through a one-deep valid/ready holding register that is
// consumed at every frame start.
// Optional feature: define I2S_TX_REPEAT_EN to repeat the previous pair on
// underflow instead of sending zeros.
module i2s_tx #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned DATA_W    = 24
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic [DATA_W-1:0] i_dataL,
    input  logic [DATA_W-1:0] i_dataR,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_sck,
    output logic              o_ws,
    output logic              o_sd,
    output logic              o_underflow
);

    localparam int unsigned DivW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FrameBits = 2 * SLOT_BITS;
    localparam int unsigned KW        = $clog2(FrameBits);

    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [KW-1:0]   KLast   = KW'(FrameBits - 1);
    localparam logic [KW-1:0]   KSlot   = KW'(SLOT_BITS);

    // Divider / serial clock state
    logic [DivW-1:0]   r_div;
    logic              r_sck;

    // Frame position and serial outputs
    logic [KW-1:0]     r_k;
    logic              r_ws;
    logic              r_sd;
    logic              r_underflow;

    // Holding register and the pair currently being shifted out
    logic              r_full;
    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;
    logic [DATA_W-1:0] r_act_l;
    logic [DATA_W-1:0] r_act_r;

    logic              w_tick;
    logic              w_fall;
    logic [DivW-1:0]   w_div_next;
    logic [KW-1:0]     w_k_next;
    logic              w_frame_start;
    logic              w_xfer;
    logic              w_in_right;
    logic [KW-1:0]     w_pos;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_shifted;
    logic              w_bit;

    // Divider wrap, sck edge qualification and frame-index advance
    always_comb begin
        w_tick        = (r_div == DivLast);
        w_fall        = w_tick & r_sck;
        w_div_next    = w_tick ? '0 : r_div + DivW'(1);
        w_k_next      = (r_k == KLast) ? '0 : r_k + KW'(1);
        w_frame_start = w_fall & (w_k_next == '0);
        w_xfer        = i_valid & ~r_full;
    end

    // Stream bit r_k of the active pair; this is what goes out at the fall
    // producing index r_k+1 (at frame start r_act still holds the old pair).
    // Shift amounts >= DATA_W naturally yield the zero padding bits.
    always_comb begin
        w_in_right = (r_k >= KSlot);
        w_pos      = w_in_right ? (r_k - KSlot) : r_k;
        w_word     = w_in_right ? r_act_r : r_act_l;
        w_shifted  = w_word << w_pos;
        w_bit      = w_shifted[DATA_W-1];
    end

    // Clock divider and serial clock toggle
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_div <= '0;
            r_sck <= 1'b0;
        end else begin
            r_div <= w_div_next;
            if (w_tick) begin
                r_sck <= ~r_sck;
            end
        end
    end

    // Bit index, word select and serial data all update on sck falls only
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_k  <= KLast;
            r_ws <= 1'b1;
            r_sd <= 1'b0;
        end else if (w_fall) begin
            r_k  <= w_k_next;
            r_ws <= (w_k_next >= KSlot);
            r_sd <= w_bit;
        end
    end

    // Holding register: load on handshake, empty when a frame start takes it
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_full   <= 1'b0;
            r_hold_l <= '0;
            r_hold_r <= '0;
        end else if (w_frame_start && r_full) begin
            r_full <= 1'b0;
        end else if (w_xfer) begin
            r_full   <= 1'b1;
            r_hold_l <= i_dataL;
            r_hold_r <= i_dataR;
        end
    end

    // Active pair capture at frame start, with underflow handling
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_act_l <= '0;
            r_act_r <= '0;
        end else if (w_frame_start) begin
            if (r_full) begin
                r_act_l <= r_hold_l;
                r_act_r <= r_hold_r;
            end else begin
`ifdef I2S_TX_REPEAT_EN
                r_act_l <= r_act_l;
                r_act_r <= r_act_r;
`else
                r_act_l <= '0;
                r_act_r <= '0;
`endif
            end
        end
    end

    // Underflow pulse, high for the single cycle after an empty frame start
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= w_frame_start & ~r_full;
        end
    end

    assign o_ready     = ~r_full;
    assign o_sck       = r_sck;
    assign o_ws        = r_ws;
    assign o_sd        = r_sd;
    assign o_underflow = r_underflow;

endmodule
